// File: rtl/eth_arp_pkg.sv
// Shared constants and types for the ARP receive path.
// Halfword constants are in wire order: the first byte on the wire sits in [7:0].
package eth_arp_pkg;

  localparam int IDX_W = 5;

  localparam logic [IDX_W-1:0] IDX_FIRST  = 5'd1;
  localparam logic [IDX_W-1:0] IDX_DST_LO = 5'd1;
  localparam logic [IDX_W-1:0] IDX_DST_HI = 5'd3;
  localparam logic [IDX_W-1:0] IDX_ETYPE  = 5'd7;
  localparam logic [IDX_W-1:0] IDX_HTYPE  = 5'd8;
  localparam logic [IDX_W-1:0] IDX_PTYPE  = 5'd9;
  localparam logic [IDX_W-1:0] IDX_LENS   = 5'd10;
  localparam logic [IDX_W-1:0] IDX_OPER   = 5'd11;
  localparam logic [IDX_W-1:0] IDX_SHA0   = 5'd12;
  localparam logic [IDX_W-1:0] IDX_SHA1   = 5'd13;
  localparam logic [IDX_W-1:0] IDX_SHA2   = 5'd14;
  localparam logic [IDX_W-1:0] IDX_SPA0   = 5'd15;
  localparam logic [IDX_W-1:0] IDX_SPA1   = 5'd16;
  localparam logic [IDX_W-1:0] IDX_TPA0   = 5'd20;
  localparam logic [IDX_W-1:0] IDX_TPA1   = 5'd21;
  localparam logic [IDX_W-1:0] IDX_MAX    = 5'd22;

  localparam logic [15:0] HW_ETYPE_ARP = 16'h06_08;
  localparam logic [15:0] HW_HTYPE_ETH = 16'h01_00;
  localparam logic [15:0] HW_PTYPE_IP4 = 16'h00_08;
  localparam logic [15:0] HW_LENS      = 16'h04_06;
  localparam logic [15:0] HW_OP_REQ    = 16'h01_00;
  localparam logic [15:0] HW_OP_REP    = 16'h02_00;
  localparam logic [15:0] HW_BCAST     = 16'hff_ff;

  typedef enum logic {
    ST_RECV  = 1'b0,
    ST_DRAIN = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic        is_reply;
    logic [47:0] sender_mac;
    logic [31:0] sender_ip;
    logic [7:0]  frame_no;
  } arp_result_t;

  // Wire-order halfword to MSB-first byte pair.
  function automatic logic [15:0] swap16(input logic [15:0] hw);
    return {hw[7:0], hw[15:8]};
  endfunction

endpackage

// File: rtl/eth_arp_result_buf.sv
// One-entry valid/ready holding register for parsed ARP results.
// A push is taken when empty or draining this cycle; otherwise it is flagged as overflow.
module eth_arp_result_buf
  import eth_arp_pkg::*;
(
  input  logic        pll_clk_axis_out,
  input  logic        pll_resetn_out,
  input  logic        push,
  input  arp_result_t push_data,
  input  logic        ready,
  output logic        valid,
  output arp_result_t data,
  output logic        accept,
  output logic        overflow
);

  assign accept   = push && (!valid || ready);
  assign overflow = push && valid && !ready;

  always_ff @(posedge pll_clk_axis_out or negedge pll_resetn_out) begin
    if (!pll_resetn_out) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_arp_rx_parser.sv
// ARP frame parser on a 16-bit AXI-Stream feed: validates header, destination and
// target IP, captures sender MAC/IP and hands the result out through a one-entry buffer.
module eth_arp_rx_parser
  import eth_arp_pkg::*;
#(
  parameter int SIM_DELAY = 0
) (
  input  logic        pll_clk_axis_out,
  input  logic        pll_resetn_out,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [23:0] s_axis_data,
  input  logic [1:0]  s_axis_keep,
  input  logic        s_axis_last,
  input  logic        s_axis_valid,
  output logic        arp_valid,
  input  logic        arp_ready,
  output logic        arp_is_reply,
  output logic [47:0] arp_sender_mac,
  output logic [31:0] arp_sender_ip,
  output logic [7:0]  arp_frame_no,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt,
  output logic [7:0]  ovf_cnt
);

  // Registers update with zero delay; a negative setting is a configuration error.
  if (SIM_DELAY < 0) begin : g_bad_sim_delay
    $error("eth_arp_rx_parser: SIM_DELAY must be non-negative");
  end

  rx_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             dst_bc, dst_uc, dst_bc_nxt, dst_uc_nxt;
  logic             op_reply;
  logic [47:0]      sha;
  logic [31:0]      spa;

  logic [15:0] hw, be;
  logic        fail;
  logic        push, drop_evt, accept, overflow;
  arp_result_t push_data, res;

  assign hw = s_axis_data[15:0];
  assign be = swap16(hw);

  // Per-beat checks against the current halfword index.
  always_comb begin
    fail       = 1'b0;
    dst_bc_nxt = dst_bc;
    dst_uc_nxt = dst_uc;
    if (idx <= IDX_TPA1 && s_axis_keep != 2'b11) fail = 1'b1;
    case (idx)
      5'd1: begin
        dst_bc_nxt = (hw == HW_BCAST);
        dst_uc_nxt = (be == local_mac[47:32]);
      end
      5'd2: begin
        dst_bc_nxt = dst_bc && (hw == HW_BCAST);
        dst_uc_nxt = dst_uc && (be == local_mac[31:16]);
      end
      IDX_DST_HI: begin
        dst_bc_nxt = dst_bc && (hw == HW_BCAST);
        dst_uc_nxt = dst_uc && (be == local_mac[15:0]);
        if (!(dst_bc_nxt || dst_uc_nxt)) fail = 1'b1;
      end
      IDX_ETYPE: if (hw != HW_ETYPE_ARP) fail = 1'b1;
      IDX_HTYPE: if (hw != HW_HTYPE_ETH) fail = 1'b1;
      IDX_PTYPE: if (hw != HW_PTYPE_IP4) fail = 1'b1;
      IDX_LENS:  if (hw != HW_LENS) fail = 1'b1;
      IDX_OPER:  if (hw != HW_OP_REQ && hw != HW_OP_REP) fail = 1'b1;
      IDX_TPA0:  if (be != local_ip[31:16]) fail = 1'b1;
      IDX_TPA1:  if (be != local_ip[15:0]) fail = 1'b1;
      default: ;
    endcase
    if (s_axis_last && idx < IDX_TPA1) fail = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop_evt  = 1'b0;
    if (s_axis_valid) begin
      case (state)
        ST_RECV: begin
          if (s_axis_last) begin
            push     = !fail;
            drop_evt = fail;
          end else if (fail) begin
            state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (s_axis_last) begin
            drop_evt  = 1'b1;
            state_nxt = ST_RECV;
          end
        end
        default: state_nxt = ST_RECV;
      endcase
    end
  end

  always_ff @(posedge pll_clk_axis_out or negedge pll_resetn_out) begin
    if (!pll_resetn_out) begin
      state  <= ST_RECV;
      idx    <= IDX_FIRST;
      dst_bc <= 1'b0;
      dst_uc <= 1'b0;
    end else if (s_axis_valid) begin
      state  <= state_nxt;
      dst_bc <= dst_bc_nxt;
      dst_uc <= dst_uc_nxt;
      if (s_axis_last)     idx <= IDX_FIRST;
      else if (idx != IDX_MAX) idx <= idx + 5'd1;
    end
  end

  // Sender fields are captured regardless of check state; only a passing frame publishes them.
  always_ff @(posedge pll_clk_axis_out or negedge pll_resetn_out) begin
    if (!pll_resetn_out) begin
      op_reply <= 1'b0;
      sha      <= '0;
      spa      <= '0;
    end else if (s_axis_valid) begin
      case (idx)
        IDX_OPER: op_reply     <= (hw == HW_OP_REP);
        IDX_SHA0: sha[47:32]   <= be;
        IDX_SHA1: sha[31:16]   <= be;
        IDX_SHA2: sha[15:0]    <= be;
        IDX_SPA0: spa[31:16]   <= be;
        IDX_SPA1: spa[15:0]    <= be;
        default: ;
      endcase
    end
  end

  assign push_data = '{is_reply:   op_reply,
                       sender_mac: sha,
                       sender_ip:  spa,
                       frame_no:   s_axis_data[23:16]};

  eth_arp_result_buf u_result_buf (
    .pll_clk_axis_out (pll_clk_axis_out),
    .pll_resetn_out   (pll_resetn_out),
    .push             (push),
    .push_data        (push_data),
    .ready            (arp_ready),
    .valid            (arp_valid),
    .data             (res),
    .accept           (accept),
    .overflow         (overflow)
  );

  assign arp_is_reply   = res.is_reply;
  assign arp_sender_mac = res.sender_mac;
  assign arp_sender_ip  = res.sender_ip;
  assign arp_frame_no   = res.frame_no;

  always_ff @(posedge pll_clk_axis_out or negedge pll_resetn_out) begin
    if (!pll_resetn_out) begin
      good_cnt <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (accept)   good_cnt <= good_cnt + 16'd1;
      if (drop_evt) drop_cnt <= drop_cnt + 16'd1;
      if (overflow && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule
